// File: rtl/bird_physics.sv
// Vertical physics for the bird: one gravity/flap step per rising edge of the
// frame tick, plus floor, ceiling and pipe-collision handling.
module bird_physics #(
    parameter int SCREEN_H = 480,
    parameter int BIRD_H   = 16,
    parameter int START_Y  = 240,
    parameter int GRAVITY  = 1,
    parameter int FLAP_VEL = -8,
    parameter int MAX_FALL = 10
) (
    input  logic       inClock,
    input  logic       reset,
    input  logic       tickIn,
    input  logic       flap,
    input  logic       start,
    input  logic       collide,
    output logic [9:0] birdY,
    output logic [7:0] velocity,
    output logic [1:0] state,
    output logic       gameOver,
    output logic       stepPulse
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLYING = 2'd1,
        DEAD   = 2'd2
    } state_t;

    localparam logic [9:0]         START_Y_V = 10'(START_Y);
    localparam logic [9:0]         FLOOR_Y   = 10'(SCREEN_H - BIRD_H);
    localparam logic signed [11:0] FLOOR_S   = 12'(SCREEN_H - BIRD_H);
    localparam logic signed [11:0] GRAV_S    = 12'(GRAVITY);
    localparam logic signed [11:0] FLAP_S    = 12'(FLAP_VEL);
    localparam logic signed [11:0] MAXF_S    = 12'(MAX_FALL);

    state_t st;
    logic   tickPrev, flapPrev, flapPending;
    logic   step, flapEdge;

    logic signed [11:0] vel_ext, vel_inc, v_next, y_next;

    assign step     = tickIn & ~tickPrev;
    assign flapEdge = flap & ~flapPrev;
    assign state    = st;

    // A flap edge arriving on the step cycle itself still counts for that step.
    always_comb begin
        vel_ext = {{4{velocity[7]}}, velocity};
        vel_inc = vel_ext + GRAV_S;
        if (flapPending | flapEdge)
            v_next = FLAP_S;
        else if (vel_inc > MAXF_S)
            v_next = MAXF_S;
        else
            v_next = vel_inc;
        y_next = $signed({2'b00, birdY}) + v_next;
    end

    always_ff @(posedge inClock) begin
        if (reset) begin
            birdY       <= START_Y_V;
            velocity    <= 8'd0;
            st          <= IDLE;
            gameOver    <= 1'b0;
            stepPulse   <= 1'b0;
            tickPrev    <= 1'b0;
            flapPrev    <= 1'b0;
            flapPending <= 1'b0;
        end else begin
            tickPrev  <= tickIn;
            flapPrev  <= flap;
            stepPulse <= step;
            case (st)
                IDLE: begin
                    birdY       <= START_Y_V;
                    velocity    <= 8'd0;
                    flapPending <= 1'b0;
                    if (start)
                        st <= FLYING;
                end
                FLYING: begin
                    if (collide) begin
                        st       <= DEAD;
                        gameOver <= 1'b1;
                    end else if (step) begin
                        flapPending <= 1'b0;
                        if (y_next[11]) begin
                            birdY    <= 10'd0;
                            velocity <= v_next[7:0];
                        end else if (y_next >= FLOOR_S) begin
                            birdY    <= FLOOR_Y;
                            velocity <= 8'd0;
                            st       <= DEAD;
                            gameOver <= 1'b1;
                        end else begin
                            birdY    <= y_next[9:0];
                            velocity <= v_next[7:0];
                        end
                    end else if (flapEdge) begin
                        flapPending <= 1'b1;
                    end
                end
                DEAD: begin
                    flapPending <= 1'b0;
                    if (start) begin
                        st       <= IDLE;
                        gameOver <= 1'b0;
                        birdY    <= START_Y_V;
                        velocity <= 8'd0;
                    end
                end
                default: begin
                    st       <= IDLE;
                    gameOver <= 1'b0;
                end
            endcase
        end
    end

endmodule
